// File: rtl/alu_result_stage.sv
// ALU result stage: condition evaluation against the architectural NZCV register,
// flag update, squash counting and a small writeback FIFO with valid/ready on both sides.
module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_n,
  input  logic              in_z,
  input  logic              in_c,
  input  logic              in_v,
  input  logic              in_set_flags,
  input  logic              in_wb_en,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [3:0]        in_cond,
  output logic              cond_pass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic [3:0]        flags_nzcv,
  output logic [CNT_W-1:0]  squash_cnt
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

  logic [3:0]              nzcv;
  logic [CNT_BITS-1:0]     count;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [DATA_W+RD_W-1:0]  mem [DEPTH];
  logic                    acc;
  logic                    push;
  logic                    pop;
  logic                    f_n, f_z, f_c, f_v;

  assign {f_n, f_z, f_c, f_v} = nzcv;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cond_pass = 1'b1;
    case (cond_e'(in_cond))
      COND_EQ: cond_pass = f_z;
      COND_NE: cond_pass = !f_z;
      COND_CS: cond_pass = f_c;
      COND_CC: cond_pass = !f_c;
      COND_MI: cond_pass = f_n;
      COND_PL: cond_pass = !f_n;
      COND_VS: cond_pass = f_v;
      COND_VC: cond_pass = !f_v;
      COND_HI: cond_pass = f_c && !f_z;
      COND_LS: cond_pass = !f_c || f_z;
      COND_GE: cond_pass = (f_n == f_v);
      COND_LT: cond_pass = (f_n != f_v);
      COND_GT: cond_pass = !f_z && (f_n == f_v);
      COND_LE: cond_pass = f_z || (f_n != f_v);
      default: cond_pass = 1'b1;
    endcase
  end

  // Room is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign in_ready  = !rst && (count < DEPTH_C);
  assign out_valid = !rst && (count != '0);
  assign acc       = in_valid && in_ready;
  assign push      = acc && cond_pass && in_wb_en;
  assign pop       = out_valid && out_ready;

  assign out_result = out_valid ? mem[rd_ptr][DATA_W+RD_W-1:RD_W] : '0;
  assign out_rd     = out_valid ? mem[rd_ptr][RD_W-1:0] : '0;
  assign flags_nzcv = nzcv;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv       <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      squash_cnt <= '0;
    end else begin
      if (acc && cond_pass && in_set_flags)
        nzcv <= {in_n, in_z, in_c, in_v};
      if (acc && !cond_pass && (squash_cnt != '1))
        squash_cnt <= squash_cnt + CNT_W'(1);
      if (push)
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {in_result, in_rd};
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_n, in_z, in_c, in_v;
  logic        in_set_flags;
  logic        in_wb_en;
  logic [3:0]  in_rd;
  logic [3:0]  in_cond;
  logic        cond_pass;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic [3:0]  flags_nzcv;
  logic [15:0] squash_cnt;

  int checks   = 0;
  int failures = 0;

  alu_result_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
    .in_set_flags(in_set_flags), .in_wb_en(in_wb_en), .in_rd(in_rd), .in_cond(in_cond),
    .cond_pass(cond_pass),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .flags_nzcv(flags_nzcv), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] res, input logic [3:0] nzcv, input logic sf,
                       input logic wb, input logic [3:0] rd, input logic [3:0] cond);
    in_valid     = 1'b1;
    in_result    = res;
    {in_n, in_z, in_c, in_v} = nzcv;
    in_set_flags = sf;
    in_wb_en     = wb;
    in_rd        = rd;
    in_cond      = cond;
    #1;
  endtask

  logic [15:0] cond_tbl;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; {in_n, in_z, in_c, in_v} = 4'b0;
    in_set_flags = 1'b0; in_wb_en = 1'b0; in_rd = '0; in_cond = 4'd14;
    step(); step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", flags_nzcv, 0);
    check("rst_squash", squash_cnt, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // 1: ANDS zero result sets Z and writes rd=3
    drive(32'h0, 4'b0100, 1, 1, 4'd3, 4'd14);
    check("t1_cond_pass", cond_pass, 1);
    step();
    in_valid = 1'b0;
    check("t1_flags", flags_nzcv, 4'b0100);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_result", out_result, 0);
    check("t1_out_rd", out_rd, 3);

    // 2: NE fails with Z=1, then EQ passes
    drive(32'h55, 4'b0000, 0, 1, 4'd5, 4'd1);
    check("t2_ne_cond_pass", cond_pass, 0);
    step();
    check("t2_squash", squash_cnt, 1);
    check("t2_no_push_rd", out_rd, 3);
    check("t2_no_push_ready", in_ready, 1);
    drive(32'h55, 4'b0000, 0, 1, 4'd5, 4'd0);
    check("t2_eq_cond_pass", cond_pass, 1);
    step();
    in_valid = 1'b0;
    check("t2_full", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("t2_head0", out_rd, 3);
    step();
    check("t2_head1_rd", out_rd, 5);
    check("t2_head1_res", out_result, 32'h55);
    step();
    check("t2_empty", out_valid, 0);
    check("t2_empty_res", out_result, 0);
    out_ready = 1'b0;

    // 3 and 4a: three back-to-back ops with the sink stalled
    for (int i = 1; i <= 2; i++) begin
      drive(32'h100 + i, 4'b0000, 0, 1, 4'(i), 4'd14);
      step();
    end
    drive(32'h103, 4'b0000, 0, 1, 4'd3, 4'd14);
    check("t3_held_not_ready", in_ready, 0);
    step();
    check("t3_head_stable_rd", out_rd, 1);
    check("t3_head_stable_res", out_result, 32'h101);
    out_ready = 1'b1;
    #1;
    check("t4_full_pop_refuse", in_ready, 0);
    step();
    check("t3_drain_rd2", out_rd, 2);
    check("t4_count1_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t3_drain_rd3", out_rd, 3);
    check("t3_drain_res3", out_result, 32'h103);
    step();
    check("t3_drained", out_valid, 0);

    // 4b: count=1 with push and pop every cycle for 8 cycles
    out_ready = 1'b0;
    drive(32'h200, 4'b0000, 0, 1, 4'd0, 4'd14);
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(32'h200 + i, 4'b0000, 0, 1, 4'(i), 4'd14);
      check($sformatf("t4_wrap_rd%0d", i - 1), out_rd, i - 1);
      check($sformatf("t4_wrap_ready%0d", i), in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    check("t4_wrap_last_res", out_result, 32'h208);
    step();
    check("t4_wrap_empty", out_valid, 0);
    out_ready = 1'b0;

    // 5: back-to-back flag setters, second uses MI on the new N
    drive(32'h8000_0000, 4'b1000, 1, 0, 4'd0, 4'd14);
    step();
    drive(32'h7, 4'b0011, 1, 1, 4'd7, 4'd4);
    check("t5_flags_1000", flags_nzcv, 4'b1000);
    check("t5_mi_pass", cond_pass, 1);
    check("t5_noop_no_push", out_valid, 0);
    step();
    in_valid = 1'b0;
    check("t5_flags_0011", flags_nzcv, 4'b0011);
    check("t5_out_rd", out_rd, 7);

    // Full condition table against NZCV=0011 (N=0 Z=0 C=1 V=1)
    cond_tbl = 16'hE966;
    for (int c = 0; c < 16; c++) begin
      in_cond = 4'(c);
      #1;
      check($sformatf("cond_%0d", c), cond_pass, cond_tbl[c]);
    end

    // 6: reset with two entries buffered
    drive(32'h9, 4'b0000, 0, 1, 4'd9, 4'd14);
    step();
    in_valid = 1'b0;
    check("t6_full", in_ready, 0);
    check("t6_squash_before", squash_cnt, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_flags", flags_nzcv, 0);
    check("t6_squash", squash_cnt, 0);
    check("t6_in_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
